// File: rtl/cpu_wb_pkg.sv
// Shared types and constants for the writeback stage and register file.
// Default widths match the reference configuration (16-bit data, 16 registers);
// modules that are parameterised to other widths derive their own types
// from their parameters.
package cpu_wb_pkg;

  localparam int unsigned DATA_SIZE     = 16;
  localparam int unsigned REG_ADDR_SIZE = 4;

  typedef logic [DATA_SIZE-1:0]     data_t;
  typedef logic [REG_ADDR_SIZE-1:0] reg_addr_t;

  // One writeback pipeline entry: a result waiting to be committed.
  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
    data_t     data;
  } wb_entry_t;

  // r0 is hard-wired to zero: never written, always reads 0.
  localparam reg_addr_t REG_ZERO = '0;

endpackage : cpu_wb_pkg

// File: rtl/regfile_core.sv
// regfile_core: architectural register storage.
//   - reg_count entries of data_size bits, cleared by asynchronous reset
//   - 2 combinational read ports (rd_addr_a/b -> rd_data_a/b)
//   - 1 synchronous write port (wr_en, wr_addr, wr_data)
// r0 and out-of-range addresses read as zero and are never written.
// No forwarding is done here; bypassing belongs to the writeback stage.
module regfile_core import cpu_wb_pkg::*; #(
  parameter int unsigned data_size     = 16,
  parameter int unsigned reg_count     = 16,
  parameter int unsigned reg_addr_size = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [reg_addr_size-1:0] wr_addr,
  input  logic [data_size-1:0]     wr_data,
  input  logic [reg_addr_size-1:0] rd_addr_a,
  input  logic [reg_addr_size-1:0] rd_addr_b,
  output logic [data_size-1:0]     rd_data_a,
  output logic [data_size-1:0]     rd_data_b
);

  logic [data_size-1:0] mem [reg_count];

  logic wr_ok;
  assign wr_ok = wr_en && (wr_addr != reg_addr_size'(REG_ZERO)) && (32'(wr_addr) < reg_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < reg_count; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if ((rd_addr_a != reg_addr_size'(REG_ZERO)) && (32'(rd_addr_a) < reg_count)) begin
      rd_data_a = mem[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if ((rd_addr_b != reg_addr_size'(REG_ZERO)) && (32'(rd_addr_b) < reg_count)) begin
      rd_data_b = mem[rd_addr_b];
    end
  end

endmodule : regfile_core

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback stage feeding the register file.
//   Captures the execute-bus result (bus_data, wb_dest, unit selects) into a
//   one-entry pipeline register, then commits it to regfile_core on the next
//   unstalled edge while capturing the following result.
// Ports:
//   clk, rst                      clock, async active-high reset
//   alu_cs/comp_cs/misc_cs        a unit put a register result on the bus
//   jmp_cs                        jump cycle, no register result
//   wb_dest, bus_data             destination and data of this cycle's result
//   stall                         freeze stage; bus inputs are dropped
//   rd_addr_a/b -> rd_data_a/b    combinational read ports
//   wb_pending, wb_pending_dest   pipeline register status for hazard logic
//   retired_count                 committed-write counter (wraps)
// Build option: WB_BYPASS_EN forwards the pending pipeline data to read ports
// whose address matches the pending destination.
module writeback_regfile import cpu_wb_pkg::*; #(
  parameter int unsigned data_size     = 16,
  parameter int unsigned reg_count     = 16,
  parameter int unsigned reg_addr_size = 4,
  parameter int unsigned count_size    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_cs,
  input  logic                     comp_cs,
  input  logic                     misc_cs,
  input  logic                     jmp_cs,
  input  logic [reg_addr_size-1:0] wb_dest,
  input  logic [data_size-1:0]     bus_data,
  input  logic                     stall,
  input  logic [reg_addr_size-1:0] rd_addr_a,
  input  logic [reg_addr_size-1:0] rd_addr_b,
  output logic [data_size-1:0]     rd_data_a,
  output logic [data_size-1:0]     rd_data_b,
  output logic                     wb_pending,
  output logic [reg_addr_size-1:0] wb_pending_dest,
  output logic [count_size-1:0]    retired_count
);

  typedef struct packed {
    logic                     valid;
    logic [reg_addr_size-1:0] dest;
    logic [data_size-1:0]     data;
  } pipe_t;

  pipe_t                 pipe_q;
  pipe_t                 pipe_d;
  logic [count_size-1:0] retired_q;
  logic                  commit_en;
  logic [data_size-1:0]  core_a;
  logic [data_size-1:0]  core_b;

  // Jump-only cycles and writes to r0 never become pending writes.
  always_comb begin
    pipe_d       = '0;
    pipe_d.valid = (alu_cs | comp_cs | misc_cs) & ~jmp_cs &
                   (wb_dest != reg_addr_size'(REG_ZERO));
    pipe_d.dest  = wb_dest;
    pipe_d.data  = bus_data;
  end

  assign commit_en = ~stall & pipe_q.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q    <= '0;
      retired_q <= '0;
    end else if (!stall) begin
      pipe_q <= pipe_d;
      if (pipe_q.valid) begin
        retired_q <= retired_q + count_size'(1);
      end
    end
  end

  regfile_core #(
    .data_size     (data_size),
    .reg_count     (reg_count),
    .reg_addr_size (reg_addr_size)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (commit_en),
    .wr_addr   (pipe_q.dest),
    .wr_data   (pipe_q.data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (core_a),
    .rd_data_b (core_b)
  );

`ifdef WB_BYPASS_EN
  // A valid pipeline entry never targets r0, so a match implies address != 0.
  always_comb begin
    rd_data_a = core_a;
    if (pipe_q.valid && (rd_addr_a == pipe_q.dest)) begin
      rd_data_a = pipe_q.data;
    end
  end

  always_comb begin
    rd_data_b = core_b;
    if (pipe_q.valid && (rd_addr_b == pipe_q.dest)) begin
      rd_data_b = pipe_q.data;
    end
  end
`else
  assign rd_data_a = core_a;
  assign rd_data_b = core_b;
`endif

  assign wb_pending      = pipe_q.valid;
  assign wb_pending_dest = pipe_q.dest;
  assign retired_count   = retired_q;

endmodule : writeback_regfile
